// File: rtl/store_buffer_if.sv
// Store buffer bus: core-side load/store port plus
// the posted-write drain port to backing memory.
interface store_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_write_i;
  logic                  cpu_read_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i;
  logic [1:0]            cpu_type_i;
  logic                  flush_i;
  logic                  stall_o;
  logic [DATA_WIDTH-1:0] read_data_o;
  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [1:0]            mem_type_o;
  logic [ADDR_WIDTH-1:0] mem_raddr_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport master (
    output cpu_write_i, cpu_read_i, cpu_addr_i,
    output cpu_wdata_i, cpu_type_i, flush_i,
    output mem_ready_i, mem_rdata_i,
    input  stall_o, read_data_o, mem_valid_o,
    input  mem_addr_o, mem_wdata_o, mem_type_o,
    input  mem_raddr_o
  );

  modport slave (
    input  cpu_write_i, cpu_read_i, cpu_addr_i,
    input  cpu_wdata_i, cpu_type_i, flush_i,
    input  mem_ready_i, mem_rdata_i,
    output stall_o, read_data_o, mem_valid_o,
    output mem_addr_o, mem_wdata_o, mem_type_o,
    output mem_raddr_o
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to memory,
// word-load forwarding, stall on full/partial hit/fence.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [1:0]            type_q [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          fwd_ok;
  logic          partial;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.cpu_write_i & ~full;
  assign pop   = ~empty & bus.mem_ready_i;

  // newest live entry with the same word address
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) &&
          (addr_q[head_q + PW'(k)][ADDR_WIDTH-1:2] ==
           bus.cpu_addr_i[ADDR_WIDTH-1:2])) begin
        hit     = 1'b1;
        hit_idx = head_q + PW'(k);
      end
    end
  end

  // only a word store seen by a word load can forward
  always_comb begin
    fwd_ok  = (type_q[hit_idx] inside {2'b10, 2'b11}) &
              (bus.cpu_type_i inside {2'b10, 2'b11});
    partial = bus.cpu_read_i & hit & ~fwd_ok;
  end

  assign bus.read_data_o = (bus.cpu_read_i & hit & fwd_ok)
                         ? data_q[hit_idx]
                         : bus.mem_rdata_i;

  assign bus.stall_o = (bus.cpu_write_i & full)
                     | partial
                     | (bus.flush_i & ~empty);

  assign bus.mem_valid_o = ~empty;
  assign bus.mem_addr_o  = addr_q[head_q];
  assign bus.mem_wdata_o = data_q[head_q];
  assign bus.mem_type_o  = type_q[head_q];
  assign bus.mem_raddr_o = bus.cpu_addr_i;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      unique case (1'b1)
        push & ~pop: count_q <= count_q + 1'b1;
        pop & ~push: count_q <= count_q - 1'b1;
        default:     count_q <= count_q;
      endcase
    end
  end

  // entry payload capture at the tail
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= bus.cpu_addr_i;
      data_q[tail_q] <= bus.cpu_wdata_i;
      type_q[tail_q] <= bus.cpu_type_i;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a drain
// scoreboard fed by stimulus and popped by a monitor.
module tb_store_buffer;
  logic clk;
  logic rst;

  int total;
  int passed;
  int failed;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  t;
  } ent_t;

  ent_t exp_q[$];

  store_buffer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  store_buffer #(
    .DEPTH(4),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end else begin
      passed++;
    end
  endtask

  // drain monitor: every accepted head entry must match
  // the oldest expected store
  always @(negedge clk) begin
    if (!rst && bus.mem_valid_o && bus.mem_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        failed++;
        $display("FAIL drain_unexpected actual=%h required=none",
                 bus.mem_addr_o);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("drain_addr", bus.mem_addr_o, e.a);
        chk("drain_data", bus.mem_wdata_o, e.d);
        chk("drain_type", {30'd0, bus.mem_type_o}, {30'd0, e.t});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst)
      assert (!(bus.cpu_write_i && bus.cpu_read_i))
        else $error("write and read asserted together");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  t,
                       input bit          track);
    bus.cpu_write_i = 1'b1;
    bus.cpu_addr_i  = a;
    bus.cpu_wdata_i = d;
    bus.cpu_type_i  = t;
    if (track) exp_q.push_back('{a: a, d: d, t: t});
    step();
    bus.cpu_write_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.mem_valid_o) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(nm, {31'd0, done}, 32'd1);
    bus.mem_ready_i = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst = 1'b1;
    bus.cpu_write_i = 1'b0;
    bus.cpu_read_i  = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    bus.cpu_type_i  = 2'b10;
    bus.flush_i     = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h5A5A_5A5A;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset mid-fill discards pending stores
    store(32'h0, 32'h1, 2'b10, 1'b0);
    store(32'h4, 32'h2, 2'b10, 1'b0);
    store(32'h8, 32'h3, 2'b10, 1'b0);
    @(negedge clk);
    chk("t1_pre_valid", {31'd0, bus.mem_valid_o}, 32'd1);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("t1_valid", {31'd0, bus.mem_valid_o}, 32'd0);
    chk("t1_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("t1_rdata", bus.read_data_o, 32'h5A5A_5A5A);
    step();
    @(negedge clk);
    chk("t1_valid_next", {31'd0, bus.mem_valid_o}, 32'd0);
    step();

    // store, then forward to a word load
    bus.cpu_write_i = 1'b1;
    bus.cpu_addr_i  = 32'h100;
    bus.cpu_wdata_i = 32'hDEAD_BEEF;
    bus.cpu_type_i  = 2'b10;
    exp_q.push_back('{a: 32'h100, d: 32'hDEAD_BEEF, t: 2'b10});
    @(negedge clk);
    chk("t2_push_hidden", {31'd0, bus.mem_valid_o}, 32'd0);
    chk("t2_store_stall", {31'd0, bus.stall_o}, 32'd0);
    step();
    bus.cpu_write_i = 1'b0;
    @(negedge clk);
    chk("t2_valid", {31'd0, bus.mem_valid_o}, 32'd1);
    chk("t2_addr", bus.mem_addr_o, 32'h100);
    step();
    bus.cpu_read_i  = 1'b1;
    bus.cpu_addr_i  = 32'h100;
    bus.mem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    chk("t2_fwd", bus.read_data_o, 32'hDEAD_BEEF);
    chk("t2_fwd_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("t2_raddr", bus.mem_raddr_o, 32'h100);
    step();
    bus.cpu_read_i = 1'b0;
    drain("t2_drain");

    // fill, stall on full, one pop, wrap
    store(32'h0, 32'hA0, 2'b10, 1'b1);
    store(32'h4, 32'hA1, 2'b10, 1'b1);
    store(32'h8, 32'hA2, 2'b10, 1'b1);
    store(32'hC, 32'hA3, 2'b10, 1'b1);
    bus.cpu_write_i = 1'b1;
    bus.cpu_addr_i  = 32'h10;
    bus.cpu_wdata_i = 32'hA4;
    bus.cpu_type_i  = 2'b10;
    exp_q.push_back('{a: 32'h10, d: 32'hA4, t: 2'b10});
    @(negedge clk);
    chk("t3_full_stall", {31'd0, bus.stall_o}, 32'd1);
    step();
    @(negedge clk);
    chk("t3_full_hold", {31'd0, bus.stall_o}, 32'd1);
    chk("t3_head0", bus.mem_addr_o, 32'h0);
    step();
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    chk("t3_pop_no_lift", {31'd0, bus.stall_o}, 32'd1);
    step();
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    chk("t3_after_pop", {31'd0, bus.stall_o}, 32'd0);
    chk("t3_head1", bus.mem_addr_o, 32'h4);
    step();
    bus.cpu_write_i = 1'b0;
    drain("t3_drain");

    // sub-word overlap stalls until drained
    store(32'h201, 32'hAB, 2'b00, 1'b1);
    bus.cpu_read_i  = 1'b1;
    bus.cpu_addr_i  = 32'h200;
    bus.cpu_type_i  = 2'b10;
    bus.mem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t4_stall0", {31'd0, bus.stall_o}, 32'd1);
    step();
    @(negedge clk);
    chk("t4_stall1", {31'd0, bus.stall_o}, 32'd1);
    step();
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_stall2", {31'd0, bus.stall_o}, 32'd1);
    step();
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    chk("t4_release", {31'd0, bus.stall_o}, 32'd0);
    chk("t4_rdata", bus.read_data_o, 32'hCAFE_F00D);
    step();
    bus.cpu_read_i = 1'b0;
    store(32'h300, 32'h0102_0304, 2'b10, 1'b1);
    bus.cpu_read_i  = 1'b1;
    bus.cpu_addr_i  = 32'h302;
    bus.cpu_type_i  = 2'b00;
    bus.mem_rdata_i = 32'h77;
    @(negedge clk);
    chk("t4_byte_load", {31'd0, bus.stall_o}, 32'd1);
    step();
    bus.cpu_addr_i = 32'h304;
    bus.cpu_type_i = 2'b10;
    @(negedge clk);
    chk("t4_miss_stall", {31'd0, bus.stall_o}, 32'd0);
    chk("t4_miss_rdata", bus.read_data_o, 32'h77);
    step();
    bus.cpu_read_i = 1'b0;
    drain("t4_drain");

    // newest match wins; head held while not ready
    store(32'h40, 32'h11, 2'b10, 1'b1);
    store(32'h40, 32'h22, 2'b10, 1'b1);
    bus.cpu_read_i  = 1'b1;
    bus.cpu_addr_i  = 32'h40;
    bus.cpu_type_i  = 2'b10;
    bus.mem_rdata_i = 32'h99;
    @(negedge clk);
    chk("t5_newest", bus.read_data_o, 32'h22);
    chk("t5_stall", {31'd0, bus.stall_o}, 32'd0);
    step();
    bus.cpu_read_i  = 1'b0;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_head_a", bus.mem_wdata_o, 32'h11);
    step();
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    chk("t5_head_b", bus.mem_wdata_o, 32'h22);
    step();
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    chk("t5_held", bus.mem_wdata_o, 32'h22);
    step();
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    chk("t5_empty", {31'd0, bus.mem_valid_o}, 32'd0);
    step();

    // fence drains two entries
    store(32'h50, 32'h55, 2'b10, 1'b1);
    store(32'h54, 32'h66, 2'b10, 1'b1);
    bus.flush_i     = 1'b1;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    chk("t6_stall0", {31'd0, bus.stall_o}, 32'd1);
    step();
    @(negedge clk);
    chk("t6_stall1", {31'd0, bus.stall_o}, 32'd1);
    step();
    @(negedge clk);
    chk("t6_stall_low", {31'd0, bus.stall_o}, 32'd0);
    chk("t6_valid", {31'd0, bus.mem_valid_o}, 32'd0);
    step();
    bus.flush_i     = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
